// File: rtl/mux_rr_arbiter_if.sv
// Bundle of the two producer channels, the registered output channel and the
// per-channel acceptance counters shared by the round-robin arbiter and its environment.
interface mux_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in0_data;
  logic             in0_valid;
  logic             in0_ready;
  logic [WIDTH-1:0] in1_data;
  logic             in1_valid;
  logic             in1_ready;
  logic             sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       cnt0;
  logic [7:0]       cnt1;

  // master: the environment driving producers and the consumer
  modport master (
    output in0_data, in0_valid, in1_data, in1_valid, out_ready,
    input  in0_ready, in1_ready, sel, out_data, out_valid, cnt0, cnt1
  );

  modport slave (
    input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
    output in0_ready, in1_ready, sel, out_data, out_valid, cnt0, cnt1
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Two-channel round-robin arbiter feeding a single registered output stage,
// with a combinational mux select and wrapping per-channel acceptance counters.
module mux_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  mux_rr_arbiter_if.slave bus
);

  logic             w_load_en;
  logic             w_grant;
  logic [1:0]       w_valid;
  logic [1:0]       w_ready;
  logic [1:0]       w_accept;
  logic [WIDTH-1:0] w_data [2];

  logic             r_last_grant;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;

  assign w_valid   = {bus.in1_valid, bus.in0_valid};
  assign w_data[0] = bus.in0_data;
  assign w_data[1] = bus.in1_data;

  // Output stage can take a word when empty or when its word leaves this cycle.
  assign w_load_en = !r_out_valid || bus.out_ready;

  always_comb begin
    w_grant = r_last_grant;
    unique case (w_valid)
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = !r_last_grant;
      default: w_grant = r_last_grant;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [7:0] r_cnt;

      // Reset masks the readies so no producer sees a handshake that gets discarded.
      assign w_ready[gi]  = !rst && w_load_en && (w_grant == (gi != 0));
      assign w_accept[gi] = w_ready[gi] && w_valid[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= 8'd0;
        end else if (w_accept[gi]) begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_last_grant <= 1'b1;
    end else if (|w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= w_data[w_grant];
      r_last_grant <= w_grant;
    end else if (bus.out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign bus.sel       = w_grant;
  assign bus.in0_ready = w_ready[0];
  assign bus.in1_ready = w_ready[1];
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.cnt0      = g_ch[0].r_cnt;
  assign bus.cnt1      = g_ch[1].r_cnt;

endmodule
